wave_sequencer: RTL

//  Scheduler in front of the 5-bit signal generator: plays a programmed list of (wave type, dwell) segments
//  by driving the generator's wave_choise select. Segment switches are aligned to the generator's zero

---
 rtl/wave_seq_pkg.sv | 39 +++
 rtl/wave_seq_table.sv | 43 ++++
 rtl/wave_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/wave_seq_pkg.sv
// -----------------------------------------------------------------------------
// wave_seq_pkg
// Shared types and constants for the wave sequencer.
//   - wave_t   : generator select encoding (SQUARE=0, SAW=1, TRI=2, OFF=3)
//   - state_t  : sequencer FSM states
//   - default geometry (depth, index width, dwell width, alignment limit)
//   - segment entry layout {type[1:0], dwell[DWELL_W-1:0]} and a pack helper
// -----------------------------------------------------------------------------
package wave_seq_pkg;

    localparam int DEPTH_DEF     = 8;
    localparam int ADDR_W_DEF    = 3;
    localparam int DWELL_W_DEF   = 8;
    localparam int ALIGN_MAX_DEF = 40;
    localparam int TYPE_W        = 2;
    localparam int ENTRY_W_DEF   = TYPE_W + DWELL_W_DEF;

    typedef enum logic [1:0] {
        SQUARE = 2'd0,
        SAW    = 2'd1,
        TRI    = 2'd2,
        OFF    = 2'd3
    } wave_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_DWELL = 3'd2,
        S_ALIGN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Builds a table word for the default dwell width.
    function automatic logic [ENTRY_W_DEF-1:0] pack_entry(input wave_t t,
                                                          input logic [DWELL_W_DEF-1:0] d);
        return {t, d};
    endfunction

endpackage

// File: rtl/wave_seq_table.sv
// -----------------------------------------------------------------------------
// wave_seq_table
// Segment table: DEPTH x DATA_W register file, one synchronous write port and
// one asynchronous read port. All entries clear to zero on reset.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_we         write strobe (already qualified by the caller)
//   i_waddr      write index
//   i_wdata      write data
//   i_raddr      read index
//   o_rdata      read data (combinational)
// -----------------------------------------------------------------------------
module wave_seq_table #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // NOTE: the table is small and must read as all-zero after reset, so it is
    // built from flops with a reset rather than an inferred RAM, which has none.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/wave_sequencer.sv
// -----------------------------------------------------------------------------
// wave_sequencer
// Plays a programmed list of (wave type, dwell) segments by driving the signal
// generator's wave_choise select. Each segment is held for its dwell count and
// then until the generator output crosses zero (bounded by ALIGN_MAX cycles),
// so segment switches never cut a waveform mid-period.
// Optional build macro: WAVE_SEQ_LOOP_EN -- when defined the list repeats until
// stop, pulsing done at each wrap; otherwise it plays once and returns to OFF.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   cfg_we        table write strobe (dropped while busy)
//   cfg_addr      table entry index
//   cfg_wdata     {type[1:0], dwell[DWELL_W-1:0]}
//   cfg_len       active entry count, sampled at start (0 ignores start)
//   start         begin playback from entry 0 (ignored while busy)
//   stop          abort playback, wins over start
//   wave_in       generator output used for zero alignment
//   wave_choise   generator select (0 square, 1 saw, 2 triangle, 3 off)
//   busy          high whenever not idle
//   seg_idx       entry currently being played
//   done          one-cycle pulse at end of list
// -----------------------------------------------------------------------------
module wave_sequencer
    import wave_seq_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DWELL_W   = DWELL_W_DEF,
    parameter int ALIGN_MAX = ALIGN_MAX_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_we,
    input  logic [ADDR_W-1:0]         cfg_addr,
    input  logic [TYPE_W+DWELL_W-1:0] cfg_wdata,
    input  logic [ADDR_W:0]           cfg_len,
    input  logic                      start,
    input  logic                      stop,
    input  logic [4:0]                wave_in,
    output logic [1:0]                wave_choise,
    output logic                      busy,
    output logic [ADDR_W-1:0]         seg_idx,
    output logic                      done
);

    localparam int                ENTRY_W    = TYPE_W + DWELL_W;
    localparam int                ALIGN_W    = $clog2(ALIGN_MAX);
    localparam logic [ALIGN_W-1:0] ALIGN_LAST = ALIGN_W'(ALIGN_MAX - 1);
    localparam logic [ADDR_W:0]   LEN_MAX    = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LEN_ONE    = (ADDR_W + 1)'(1);

    state_t               r_state;
    wave_t                r_wave;
    logic [ADDR_W:0]      r_len;
    logic [ADDR_W-1:0]    r_seg_idx;
    logic [DWELL_W-1:0]   r_dwell_cnt;
    logic [ALIGN_W-1:0]   r_align_cnt;
    logic                 r_done;

    logic [ENTRY_W-1:0]   w_rd_data;
    wave_t                w_rd_type;
    logic [DWELL_W-1:0]   w_rd_dwell;
    logic                 w_tbl_we;
    logic                 w_last;
    logic                 w_aligned;
    state_t               w_adv_state;
    logic [ADDR_W-1:0]    w_adv_idx;
    logic                 w_adv_done;

    // Table is only writable while idle so a running list cannot change under us.
    assign w_tbl_we = cfg_we && (r_state == S_IDLE);

    wave_seq_table #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (ENTRY_W)
    ) u_table (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_tbl_we),
        .i_waddr (cfg_addr),
        .i_wdata (cfg_wdata),
        .i_raddr (r_seg_idx),
        .o_rdata (w_rd_data)
    );

    assign w_rd_type  = wave_t'(w_rd_data[ENTRY_W-1 -: TYPE_W]);
    assign w_rd_dwell = w_rd_data[DWELL_W-1:0];

    assign w_last    = ({1'b0, r_seg_idx} == (r_len - LEN_ONE));
    assign w_aligned = (wave_in == 5'd0) || (r_align_cnt == ALIGN_LAST);

    // Where to go once a segment is finished: from an aligned ALIGN exit or
    // from a zero-dwell entry skipped in LOAD.
    // NOTE: every signal gets a default before the if, otherwise a path that
    // leaves it unassigned would infer a latch.
    always_comb begin
        w_adv_state = S_LOAD;
        w_adv_idx   = r_seg_idx + ADDR_W'(1);
        w_adv_done  = 1'b0;
        if (w_last) begin
`ifdef WAVE_SEQ_LOOP_EN
            w_adv_idx   = '0;
            w_adv_done  = 1'b1;
`else
            w_adv_state = S_DONE;
            w_adv_idx   = r_seg_idx;
            w_adv_done  = 1'b1;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_wave      <= OFF;
            r_len       <= '0;
            r_seg_idx   <= '0;
            r_dwell_cnt <= '0;
            r_align_cnt <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if ((r_state != S_IDLE) && stop) begin
                // Abort: silence the generator, no done pulse.
                r_state     <= S_IDLE;
                r_wave      <= OFF;
                r_dwell_cnt <= '0;
                r_align_cnt <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_wave <= OFF;
                        if (start && !stop && (cfg_len != '0)) begin
                            // Clamp so the index can never run past the table.
                            r_len     <= (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
                            r_seg_idx <= '0;
                            r_state   <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        if (w_rd_dwell == '0) begin
                            // Empty segment: behave as if already aligned,
                            // keeping the current select.
                            r_state   <= w_adv_state;
                            r_seg_idx <= w_adv_idx;
                            r_done    <= w_adv_done;
                        end else begin
                            r_wave      <= w_rd_type;
                            r_dwell_cnt <= w_rd_dwell;
                            r_state     <= S_DWELL;
                        end
                    end
                    S_DWELL: begin
                        if (r_dwell_cnt != '0) begin
                            r_dwell_cnt <= r_dwell_cnt - DWELL_W'(1);
                        end
                        // Leaving on the count of one gives exactly dwell cycles here.
                        if (r_dwell_cnt <= DWELL_W'(1)) begin
                            r_align_cnt <= '0;
                            r_state     <= S_ALIGN;
                        end
                    end
                    S_ALIGN: begin
                        if (w_aligned) begin
                            r_state   <= w_adv_state;
                            r_seg_idx <= w_adv_idx;
                            r_done    <= w_adv_done;
                        end else begin
                            r_align_cnt <= r_align_cnt + ALIGN_W'(1);
                        end
                    end
                    S_DONE: begin
                        r_wave  <= OFF;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_wave  <= OFF;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign wave_choise = r_wave;
    assign busy        = (r_state != S_IDLE);
    assign seg_idx     = r_seg_idx;
    assign done        = r_done;

endmodule
